// File: rtl/imem_ctrl_pkg.sv
// imem_ctrl_pkg
// Shared definitions for the instruction-memory boot controller:
//   state_t       - controller states (LOAD, FILL, RUN, FAULT)
//   NOP_INSTR     - RISC-V canonical NOP (addi x0, x0, 0)
//   FLT_*         - fault_code encodings reported by imem_boot_ctrl
// FILL is only ever entered when IMEM_BOOT_FILL_EN is defined; the
// encoding is kept here so every build shares the same state type.
package imem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [1:0] FLT_NONE     = 2'b00;
  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_RANGE    = 2'b10;
  localparam logic [1:0] FLT_OVERFLOW = 2'b11;

endpackage

// File: rtl/imem_boot_ctrl_fetch_check.sv
// imem_fetch_check
// Purely combinational validity check of a CPU fetch address.
// Ports:
//   fetch_addr  in  32  CPU PC (byte address)
//   bad         out 1   address is not usable for a fetch
//   code        out 2   FLT_MISALIGN / FLT_RANGE when bad, FLT_NONE otherwise
// Misalignment is reported in preference to out-of-range.
module imem_fetch_check
  import imem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic [31:0] fetch_addr,
  output logic        bad,
  output logic [1:0]  code
);

  // Any set bit above the memory's byte-address window means the PC
  // points past the end of instruction memory.
  always_comb begin
    bad  = 1'b0;
    code = FLT_NONE;
    if (fetch_addr[1:0] != 2'b00) begin
      bad  = 1'b1;
      code = FLT_MISALIGN;
    end else if (fetch_addr[31:ADDR_W] != '0) begin
      bad  = 1'b1;
      code = FLT_RANGE;
    end
  end

endmodule

// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl
// Owns the instruction memory of the single-cycle core. While loading it
// streams program words into memory and holds the CPU; once the last word
// arrives it hands the memory read port to the fetch path. Bad fetches and
// load overflow latch a sticky fault that only rst clears.
// Optional feature macro: IMEM_BOOT_FILL_EN - after a short program, pad
// the rest of memory with NOPs (FILL state) before releasing the CPU.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   load_valid/load_data/load_last  program-load stream (valid/ready)
//   load_ready                    controller accepts a word this cycle
//   reload                        pulse to return from RUN to LOAD
//   fetch_addr / fetch_instr      CPU fetch path (combinational)
//   cpu_hold                      CPU must not advance its PC
//   fault / fault_code            sticky fault and its cause
//   word_cnt                      words written since entering LOAD
//   mem_we/mem_addr/mem_wdata/mem_rdata  word-wide memory port
module imem_boot_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              reload,
  input  logic [31:0]       fetch_addr,
  output logic [31:0]       fetch_instr,
  output logic              cpu_hold,
  output logic              fault,
  output logic [1:0]        fault_code,
  output logic [ADDR_W-2:0] word_cnt,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int WORDS = 1 << (ADDR_W - 2);
  // word_cnt is one bit wider than a word index so that a full load can
  // report WORDS words written.
  localparam logic [ADDR_W-2:0] LAST_IDX = (ADDR_W-1)'(WORDS - 1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-2:0] cnt_next;
  logic [1:0]        code_next;
  logic              fetch_bad;
  logic [1:0]        fetch_code;
  logic              xfer;

  imem_fetch_check #(
    .ADDR_W(ADDR_W)
  ) u_fetch_check (
    .fetch_addr(fetch_addr),
    .bad       (fetch_bad),
    .code      (fetch_code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_LOAD;
      word_cnt   <= '0;
      fault_code <= FLT_NONE;
    end else begin
      state      <= state_next;
      word_cnt   <= cnt_next;
      fault_code <= code_next;
    end
  end

  // Next-state and output decode. The memory port is muxed between the
  // load counter (LOAD/FILL) and the PC (RUN). Writes are gated by rst so
  // a reset aborts a load or fill on the very edge it is sampled.
  always_comb begin
    state_next  = state;
    cnt_next    = word_cnt;
    code_next   = fault_code;
    load_ready  = 1'b0;
    xfer        = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = word_cnt[ADDR_W-3:0];
    mem_wdata   = load_data;
    fetch_instr = NOP_INSTR;
    cpu_hold    = 1'b1;
    fault       = 1'b0;

    case (state)
      ST_LOAD: begin
        load_ready = !rst;
        xfer       = load_valid && !rst;
        mem_we     = xfer;
        if (xfer) begin
          if (load_last) begin
`ifdef IMEM_BOOT_FILL_EN
            if (word_cnt < LAST_IDX) state_next = ST_FILL;
            else                     state_next = ST_RUN;
`else
            state_next = ST_RUN;
`endif
            cnt_next = word_cnt + 1'b1;
          end else if (word_cnt == LAST_IDX) begin
            // Last word slot used without load_last: word is kept, count
            // stays saturated at the final index.
            state_next = ST_FAULT;
            code_next  = FLT_OVERFLOW;
          end else begin
            cnt_next = word_cnt + 1'b1;
          end
        end
      end

`ifdef IMEM_BOOT_FILL_EN
      ST_FILL: begin
        mem_we    = !rst;
        mem_wdata = NOP_INSTR;
        cnt_next  = word_cnt + 1'b1;
        if (word_cnt == LAST_IDX) state_next = ST_RUN;
      end
`endif

      ST_RUN: begin
        mem_addr = fetch_addr[ADDR_W-1:2];
        cpu_hold = 1'b0;
        // A bad fetch wins over reload and feeds the CPU a NOP.
        if (fetch_bad) begin
          state_next = ST_FAULT;
          code_next  = fetch_code;
        end else begin
          fetch_instr = mem_rdata;
          if (reload) begin
            state_next = ST_LOAD;
            cnt_next   = '0;
          end
        end
      end

      ST_FAULT: begin
        fault = 1'b1;
      end

      default: begin
        state_next = ST_LOAD;
      end
    endcase
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// tb_imem_boot_ctrl
// Directed scenarios plus randomized traffic for imem_boot_ctrl (ADDR_W=4,
// four words). A behavioural model tracks controller phase, load count,
// fault code and expected memory image; the DUT's memory port drives a
// separate bench-side array so fetches prove the writes really landed.
module tb_imem_boot_ctrl;

  localparam int          AW    = 4;
  localparam int          WORDS = 1 << (AW - 2);
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ADD_I = 32'h0020_81b3;
  localparam logic [31:0] SUB_I = 32'h4020_81b3;
  localparam logic [31:0] SLL_I = 32'h0020_91b3;
`ifdef IMEM_BOOT_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  localparam int P_LOAD  = 0;
  localparam int P_FILL  = 1;
  localparam int P_RUN   = 2;
  localparam int P_FAULT = 3;

  logic          clk;
  logic          rst;
  logic          load_valid;
  logic [31:0]   load_data;
  logic          load_last;
  logic          load_ready;
  logic          reload;
  logic [31:0]   fetch_addr;
  logic [31:0]   fetch_instr;
  logic          cpu_hold;
  logic          fault;
  logic [1:0]    fault_code;
  logic [AW-2:0] word_cnt;
  logic          mem_we;
  logic [AW-3:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic [31:0] tb_mem     [WORDS];
  logic [31:0] seed_vals  [WORDS];
  logic [31:0] ref_mem    [WORDS];
  logic        init_mem;

  int checks   = 0;
  int failures = 0;
  int m_phase;
  int m_cnt;
  int m_code;

  imem_boot_ctrl #(
    .ADDR_W(AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .reload     (reload),
    .fetch_addr (fetch_addr),
    .fetch_instr(fetch_instr),
    .cpu_hold   (cpu_hold),
    .fault      (fault),
    .fault_code (fault_code),
    .word_cnt   (word_cnt),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side instruction memory: random power-up contents, never cleared.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < WORDS; i++) tb_mem[i] <= seed_vals[i];
    end else if (mem_we) begin
      tb_mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = tb_mem[mem_addr];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs against the
  // model, clock, advance the model by the specified rules, check registers.
  task automatic applyStimulus(input logic r, input logic v, input logic [31:0] d,
                               input logic l, input logic rl, input logic [31:0] a);
    logic        bad;
    logic [31:0] exp_instr;
    rst        = r;
    load_valid = v;
    load_data  = d;
    load_last  = l;
    reload     = rl;
    fetch_addr = a;
    #2;
    bad       = (a % 4 != 0) || (a >= 32'(WORDS * 4));
    exp_instr = NOP;
    if (m_phase == P_RUN && !bad) exp_instr = ref_mem[a / 4];
    checkOutput("load_ready", 32'(load_ready), 32'(m_phase == P_LOAD && !r));
    checkOutput("cpu_hold", 32'(cpu_hold), 32'(m_phase != P_RUN));
    checkOutput("fetch_instr", fetch_instr, exp_instr);
    checkOutput("mem_we", 32'(mem_we),
                32'(!r && ((m_phase == P_LOAD && v) || m_phase == P_FILL)));
    @(posedge clk);
    if (r) begin
      m_phase = P_LOAD;
      m_cnt   = 0;
      m_code  = 0;
    end else begin
      case (m_phase)
        P_LOAD: if (v) begin
          ref_mem[m_cnt] = d;
          if (l) begin
            m_phase = (FILL_EN && m_cnt < WORDS - 1) ? P_FILL : P_RUN;
            m_cnt++;
          end else if (m_cnt == WORDS - 1) begin
            m_phase = P_FAULT;
            m_code  = 3;
          end else begin
            m_cnt++;
          end
        end
        P_FILL: begin
          ref_mem[m_cnt] = NOP;
          if (m_cnt == WORDS - 1) m_phase = P_RUN;
          m_cnt++;
        end
        P_RUN: begin
          if (a % 4 != 0) begin
            m_phase = P_FAULT;
            m_code  = 1;
          end else if (a >= 32'(WORDS * 4)) begin
            m_phase = P_FAULT;
            m_code  = 2;
          end else if (rl) begin
            m_phase = P_LOAD;
            m_cnt   = 0;
          end
        end
        default: ;
      endcase
    end
    #1;
    checkOutput("word_cnt", 32'(word_cnt), 32'(m_cnt));
    checkOutput("fault", 32'(fault), 32'(m_phase == P_FAULT));
    checkOutput("fault_code", 32'(fault_code), 32'(m_code));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    load_last  = 1'b0;
    reload     = 1'b0;
    fetch_addr = '0;
    for (int i = 0; i < WORDS; i++) begin
      seed_vals[i] = $urandom;
      ref_mem[i]   = seed_vals[i];
    end
    init_mem = 1'b1;
    @(posedge clk);
    #1;
    init_mem = 1'b0;
    m_phase  = P_LOAD;
    m_cnt    = 0;
    m_code   = 0;

    // Second reset cycle, then a three-instruction program.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, ADD_I, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, SUB_I, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, SLL_I, 1'b1, 1'b0, 32'h0);
    checkOutput("load3_word_cnt", 32'(word_cnt), 32'd3);
    idle(1);
    fetch_addr = 32'h4;
    #1;
    checkOutput("fetch_sub", fetch_instr, SUB_I);
    checkOutput("run_hold", 32'(cpu_hold), 32'd0);

    // Random in-range fetches.
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'($urandom_range(0, WORDS - 1) * 4));

    // Misaligned fetch; reload must not escape FAULT.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h6);
    checkOutput("misalign_code", 32'(fault_code), 32'd1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Overflow: fill every slot without load_last.
    for (int i = 0; i < WORDS; i++) applyStimulus(1'b0, 1'b1, $urandom, 1'b0, 1'b0, 32'h0);
    checkOutput("overflow_code", 32'(fault_code), 32'd3);
    idle(1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Out-of-range fetch together with reload: fault has priority.
    applyStimulus(1'b0, 1'b1, $urandom, 1'b1, 1'b0, 32'h0);
    idle(WORDS);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'(WORDS * 4));
    checkOutput("range_code", 32'(fault_code), 32'd2);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Reset in the middle of a load, then a one-word program.
    applyStimulus(1'b0, 1'b1, $urandom, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, $urandom, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, $urandom, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, $urandom, 1'b1, 1'b0, 32'h0);
    idle(WORDS);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h4);

    // Randomized traffic; reset whenever the model has faulted.
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      if (m_phase == P_FAULT) begin
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      end else begin
        a = 32'($urandom_range(0, WORDS - 1) * 4);
        if ($urandom_range(0, 15) == 0) a = a | 32'($urandom_range(1, 3));
        if ($urandom_range(0, 15) == 0) a = a + 32'(WORDS * 4 * $urandom_range(1, 8));
        applyStimulus(1'b0, 1'($urandom_range(0, 1)), $urandom,
                      1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0), a);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
